centroid_calc: RTL

Handshake responder that computes the centroid of all pixels matching a colour key in the 320x240 RGB444 frame buffer. The main control FSM starts it with the same start/started/done/ack protocol used for the photo and min/max blocks. The block scans the frame through the second read port of a block RAM (1-cycle read latency). It returns `x_cen`/`y_cen`, which feed the overlay block's centre-marker inputs.

---
 rtl/centroid_calc.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/centroid_calc.sv
// centroid_calc
// Scans an IMG_W x IMG_H RGB444 frame through a 1-cycle-latency RAM read port,
// accumulates the column/row of every pixel that matches the colour key and
// divides the sums by the match count to give the centroid.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start_flag        initiator request, held until done_flag is seen
//   ack_flag          initiator acknowledge of done or error
//   data_pixel        RAM data {R,G,B}, valid one cycle after its address
//   address_to_read   RAM read address (0 outside SCAN)
//   started_flag      busy (SCAN/DRAIN/DIV)
//   done_flag         result valid, held until ack
//   error_flag        initiator dropped start mid-transaction
//   found, pixel_count, x_cen, y_cen   registered results
module centroid_calc #(
    parameter int         IMG_W = 320,
    parameter int         IMG_H = 240,
    parameter logic [3:0] R_MIN = 4'hA,
    parameter logic [3:0] G_MAX = 4'h5,
    parameter logic [3:0] B_MAX = 4'h5,
    parameter int         SUM_W = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_flag,
    input  logic        ack_flag,
    input  logic [11:0] data_pixel,
    output logic [16:0] address_to_read,
    output logic        started_flag,
    output logic        done_flag,
    output logic        error_flag,
    output logic        found,
    output logic [16:0] pixel_count,
    output logic [8:0]  x_cen,
    output logic [8:0]  y_cen
);
    localparam logic [16:0] LAST_ADDR = 17'(IMG_W * IMG_H - 1);
    localparam logic [8:0]  LAST_COL  = 9'(IMG_W - 1);
    localparam int          DCNT_W    = $clog2(SUM_W);
    localparam logic [DCNT_W-1:0] LAST_DIV = DCNT_W'(SUM_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_DIV, S_DONE, S_ERROR} state_t;
    state_t r_state, w_next;

    logic [16:0]       r_addr;
    logic [8:0]        r_col, r_col_d;
    logic [7:0]        r_row, r_row_d;
    logic              r_vld_d;
    logic [SUM_W-1:0]  r_sum_x, r_sum_y;
    logic [16:0]       r_count;
    logic [SUM_W-1:0]  r_qx, r_qy;
    logic [16:0]       r_rx, r_ry;
    logic [DCNT_W-1:0] r_dcnt;

    logic              w_match;
    logic [SUM_W-1:0]  w_sum_x_nxt, w_sum_y_nxt;
    logic [16:0]       w_count_nxt;
    logic [SUM_W-1:0]  w_qx_nxt, w_qy_nxt;
    logic [16:0]       w_rx_nxt, w_ry_nxt;

    // One restoring-division step: shift the next dividend bit into the
    // remainder, subtract the divisor when it fits, shift the quotient bit in.
    // The dividend occupies the quotient register and drains out of its MSB.
    function automatic logic [16+SUM_W:0] div_step(input logic [16:0] rem,
                                                   input logic [SUM_W-1:0] q,
                                                   input logic [16:0] d);
        logic [17:0] t;
        logic        bit_q;
        t     = {rem, q[SUM_W-1]};
        bit_q = (t >= {1'b0, d});
        if (bit_q) t = t - {1'b0, d};
        div_step = {t[16:0], q[SUM_W-2:0], bit_q};
    endfunction

    // Delayed valid gates the compare so only real scan data is counted.
    assign w_match = r_vld_d && (data_pixel[11:8] >= R_MIN) &&
                     (data_pixel[7:4] <= G_MAX) && (data_pixel[3:0] <= B_MAX);

    assign w_sum_x_nxt = w_match ? r_sum_x + SUM_W'(r_col_d) : r_sum_x;
    assign w_sum_y_nxt = w_match ? r_sum_y + SUM_W'(r_row_d) : r_sum_y;
    assign w_count_nxt = w_match ? r_count + 17'd1 : r_count;

    assign {w_rx_nxt, w_qx_nxt} = div_step(r_rx, r_qx, r_count);
    assign {w_ry_nxt, w_qy_nxt} = div_step(r_ry, r_qy, r_count);

    assign address_to_read = (r_state == S_SCAN) ? r_addr : 17'd0;
    assign started_flag    = (r_state == S_SCAN) || (r_state == S_DRAIN) || (r_state == S_DIV);
    assign done_flag       = (r_state == S_DONE);
    assign error_flag      = (r_state == S_ERROR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_flag && !ack_flag) w_next = S_SCAN;
            S_SCAN:  if (!start_flag) w_next = S_ERROR;
                     else if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: if (!start_flag) w_next = S_ERROR;
                     else if (w_count_nxt != 17'd0) w_next = S_DIV;
                     else w_next = S_DONE;
            S_DIV:   if (!start_flag) w_next = S_ERROR;
                     else if (r_dcnt == LAST_DIV) w_next = S_DONE;
            S_DONE,
            S_ERROR: if (ack_flag) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_col_d     <= '0;
            r_row_d     <= '0;
            r_vld_d     <= 1'b0;
            r_sum_x     <= '0;
            r_sum_y     <= '0;
            r_count     <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_dcnt      <= '0;
            found       <= 1'b0;
            pixel_count <= '0;
            x_cen       <= '0;
            y_cen       <= '0;
        end else begin
            // Column/row follow the address by one cycle to line up with RAM data.
            r_col_d <= r_col;
            r_row_d <= r_row;
            r_vld_d <= (r_state == S_SCAN);

            if (r_state == S_IDLE && w_next == S_SCAN) begin
                r_addr  <= '0;
                r_col   <= '0;
                r_row   <= '0;
                r_sum_x <= '0;
                r_sum_y <= '0;
                r_count <= '0;
            end else if (r_state == S_SCAN || r_state == S_DRAIN) begin
                r_sum_x <= w_sum_x_nxt;
                r_sum_y <= w_sum_y_nxt;
                r_count <= w_count_nxt;
                if (r_state == S_SCAN) begin
                    r_addr <= r_addr + 17'd1;
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + 8'd1;
                    end else begin
                        r_col <= r_col + 9'd1;
                    end
                end
            end

            // Divider loads from the sums including the last pixel seen in DRAIN.
            if (r_state == S_DRAIN) begin
                r_qx   <= w_sum_x_nxt;
                r_qy   <= w_sum_y_nxt;
                r_rx   <= '0;
                r_ry   <= '0;
                r_dcnt <= '0;
            end else if (r_state == S_DIV) begin
                r_qx   <= w_qx_nxt;
                r_qy   <= w_qy_nxt;
                r_rx   <= w_rx_nxt;
                r_ry   <= w_ry_nxt;
                r_dcnt <= r_dcnt + DCNT_W'(1);
            end

            if (w_next == S_DONE && r_state != S_DONE) begin
                if (r_state == S_DRAIN) begin
                    found       <= 1'b0;
                    pixel_count <= '0;
                    x_cen       <= '0;
                    y_cen       <= '0;
                end else begin
                    found       <= 1'b1;
                    pixel_count <= r_count;
                    x_cen       <= w_qx_nxt[8:0];
                    y_cen       <= w_qy_nxt[8:0];
                end
            end
        end
    end
endmodule
